// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 8-digit seven-segment path.
// A winner's value is latched and clamped, offered over valid/ready, then the
// owner is held for DWELL_CYCLES after acceptance so the value stays readable.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requesters
// SEND  | latched value offered to the display datapath (disp_valid high)
// DWELL | value accepted; owner held until the dwell count expires
module seg_display_arbiter #(
  parameter int N_REQ        = 4,
  parameter int VALUE_W      = 26,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int MAX_DISPLAY  = 99_999_999
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*VALUE_W-1:0]   req_value_i,
  output logic [N_REQ-1:0]           req_ack_o,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [26:0]                disp_value_o,
  output logic                       disp_ovf_o,
  output logic [2:0]                 grant_id_o,
  output logic                       busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DWELL} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         last_q;
  logic [2:0]         grant_q;
  logic [N_REQ-1:0]   ack_q;
  logic [26:0]        val_q;
  logic               ovf_q;

  logic               any_req;
  logic               found;
  int                 sum;
  logic [IW-1:0]      idx;
  logic [2:0]         win;
  logic [VALUE_W-1:0] sel_val;
  logic               clamp_ovf;
  logic [26:0]        clamp_val;

  assign any_req = |req_valid_i;

  // Round-robin pick: first pending index after the last owner, wrapping.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(last_q) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IW'(sum);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = 3'(sum);
      end
    end
  end

  // Select the winner's value slice.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == 3'(i)) sel_val = req_value_i[i*VALUE_W +: VALUE_W];
    end
  end

  // Clamp is resolved at latch time so disp_value/disp_ovf are plain registers.
  assign clamp_ovf = 64'(sel_val) > 64'(MAX_DISPLAY);
  assign clamp_val = clamp_ovf ? 27'(MAX_DISPLAY) : 27'(sel_val);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SEND;
      SEND:    if (disp_ready_i) state_d = DWELL;
      DWELL:   if (cnt_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched value, dwell counter and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= '0;
      grant_q <= '0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 3'(N_REQ - 1);
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ack_q   <= N_REQ'(1) << win;
            grant_q <= win;
            val_q   <= clamp_val;
            ovf_q   <= clamp_ovf;
          end
        end
        SEND: begin
          if (disp_ready_i) cnt_q <= '0;
        end
        DWELL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) last_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state plus registered data.
  always_comb begin
    disp_valid_o = (state_q == SEND);
    busy_o       = (state_q != IDLE);
    req_ack_o    = ack_q;
    disp_value_o = val_q;
    disp_ovf_o   = ovf_q;
    grant_id_o   = grant_q;
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic,
// compared every cycle against an ownership/timing reference model.
module tb_seg_display_arbiter;

  localparam int N    = 4;
  localparam int W    = 27;
  localparam int D    = 8;
  localparam int MAXD = 99_999_999;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_value;
  logic [N-1:0]   req_ack;
  logic           disp_valid;
  logic           disp_ready;
  logic [26:0]    disp_value;
  logic           disp_ovf;
  logic [2:0]     grant_id;
  logic           busy;

  logic [W-1:0]   vals [N];
  assign req_value = {vals[3], vals[2], vals[1], vals[0]};

  int n_chk = 0;
  int n_err = 0;

  // Reference model: who owns the display, whether the value is still on
  // offer, and how many ownership cycles remain after acceptance.
  int     m_last, m_grant, m_ack, m_left;
  bit     m_wait;
  longint m_val;
  bit     m_ovf;

  int ack_log[$];

  seg_display_arbiter #(
    .N_REQ(N), .VALUE_W(W), .DWELL_CYCLES(D), .MAX_DISPLAY(MAXD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_value_i(req_value), .req_ack_o(req_ack),
    .disp_valid_o(disp_valid), .disp_ready_i(disp_ready),
    .disp_value_o(disp_value), .disp_ovf_o(disp_ovf),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int id;
    logic [1:0] ix;
    for (int k = 1; k <= N; k++) begin
      id = (last + k) % N;
      ix = 2'(id);
      if (r[ix]) return id;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_grant = 0; m_ack = -1; m_left = 0;
    m_wait = 0; m_val = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] rq, input logic rdy);
    int w;
    logic [1:0] ix;
    m_ack = -1;
    if (m_wait) begin
      if (rdy) begin m_wait = 0; m_left = D; end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_last = m_grant;
    end else if (rq != 0) begin
      w = rr_pick(rq, m_last);
      ix = 2'(w);
      m_grant = w;
      m_ack = w;
      m_val = longint'(vals[ix]);
      if (m_val > MAXD) begin m_ovf = 1; m_val = MAXD; end
      else m_ovf = 0;
      m_wait = 1;
    end
  endtask

  task automatic check_outputs();
    chk("req_ack", 64'(req_ack), (m_ack >= 0) ? (64'(1) << m_ack) : 64'(0));
    chk("disp_valid", 64'(disp_valid), 64'(m_wait));
    chk("busy", 64'(busy), 64'(m_wait || m_left > 0));
    chk("grant_id", 64'(grant_id), 64'(m_grant));
    chk("disp_value", 64'(disp_value), 64'(m_val));
    chk("disp_ovf", 64'(disp_ovf), 64'(m_ovf));
  endtask

  // Called just after a falling edge: apply inputs, predict, check next fall.
  task automatic step(input logic [N-1:0] rq, input logic rdy);
    req_valid  = rq;
    disp_ready = rdy;
    model_edge(rq, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_vals();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 9))
        0:       vals[2'(i)] = W'(MAXD);
        1:       vals[2'(i)] = W'(MAXD + 1);
        2, 3:    vals[2'(i)] = W'($urandom_range(MAXD + 1, (1 << W) - 1));
        default: vals[2'(i)] = W'($urandom_range(0, MAXD));
      endcase
    end
  endtask

  int busy_cnt;
  int exp_order[4] = '{0, 1, 3, 0};
  int ovf_tab[6]   = '{120_000_000, 5, MAXD, MAXD + 1, 0, (1 << W) - 1};
  logic [N-1:0] rq_r;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    disp_ready = 1'b1;
    for (int i = 0; i < N; i++) vals[2'(i)] = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single request, value 1234; ownership spans SEND plus D dwell cycles.
    vals[0] = W'(1234);
    busy_cnt = 0;
    step(4'b0001, 1'b1);
    if (busy) busy_cnt++;
    for (int c = 0; c < 12; c++) begin
      step(4'b0000, 1'b1);
      if (busy) busy_cnt++;
    end
    chk("busy_len", 64'(busy_cnt), 64'(1 + D));

    // Held 4'b1011 after reset: round-robin order 0,1,3,0.
    do_reset();
    rand_vals();
    ack_log.delete();
    for (int c = 0; c < 40; c++) begin
      step(4'b1011, 1'b1);
      for (int i = 0; i < N; i++)
        if (((req_ack >> i) & 4'b0001) != 4'b0000) ack_log.push_back(i);
    end
    chk("grant_count", 64'(ack_log.size()), 64'(4));
    for (int g = 0; g < 4 && g < ack_log.size(); g++)
      chk("grant_order", 64'(ack_log[g]), 64'(exp_order[g]));

    // Stall in SEND for 20 cycles while other requests come and go.
    for (int c = 0; c < 12; c++) step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    for (int c = 0; c < 20; c++) begin
      rand_vals();
      step(4'($urandom_range(0, 15)), 1'b0);
    end
    for (int c = 0; c < 12; c++) step(4'b0001, 1'b1);

    // Owner drops its request part-way through the dwell.
    for (int c = 0; c < 12; c++) step(4'b0000, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    for (int c = 0; c < 14; c++) step(4'b0010, 1'b1);

    // Clamp boundaries on a single requester.
    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < 12; c++) step(4'b0000, 1'b1);
      vals[3] = W'(ovf_tab[t]);
      step(4'b1000, 1'b1);
    end
    for (int c = 0; c < 12; c++) step(4'b0000, 1'b1);

    // Reset during dwell; first grant afterwards goes to lowest pending index.
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
    req_valid = 4'b1100;
    do_reset();
    step(4'b1100, 1'b1);
    chk("first_after_reset", 64'(grant_id), 64'(2));

    // Random traffic with occasional resets.
    rq_r = '0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 3) == 0) rand_vals();
      if ($urandom_range(0, 2) == 0) rq_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) do_reset();
      step(rq_r, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
